// File: rtl/w0rm_core_writeback_arbiter_if.sv
// Writeback bundle between the execute/memory stages, decode and the register file port.
// The slave modport is the arbiter side; master is the pipeline side driving requests.
interface w0rm_core_writeback_arbiter_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int NUM_REGISTERS = 4
);
   localparam int ADDR_WIDTH = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1;

   logic                     flush;

   logic                     alu_wb_valid;
   logic                     alu_wb_ready;
   logic [ADDR_WIDTH-1:0]    alu_wb_addr;
   logic [DATA_WIDTH-1:0]    alu_wb_data;

   logic                     mem_wb_valid;
   logic                     mem_wb_ready;
   logic [ADDR_WIDTH-1:0]    mem_wb_addr;
   logic [DATA_WIDTH-1:0]    mem_wb_data;

   logic                     issue_valid;
   logic [ADDR_WIDTH-1:0]    issue_addr;
   logic [NUM_REGISTERS-1:0] reg_pending;

   logic                     port_write_enable;
   logic [ADDR_WIDTH-1:0]    port_write_addr;
   logic [DATA_WIDTH-1:0]    port_write_data;

   modport master (
      output flush,
      output alu_wb_valid, alu_wb_addr, alu_wb_data,
      input  alu_wb_ready,
      output mem_wb_valid, mem_wb_addr, mem_wb_data,
      input  mem_wb_ready,
      output issue_valid, issue_addr,
      input  reg_pending,
      input  port_write_enable, port_write_addr, port_write_data
   );

   modport slave (
      input  flush,
      input  alu_wb_valid, alu_wb_addr, alu_wb_data,
      output alu_wb_ready,
      input  mem_wb_valid, mem_wb_addr, mem_wb_data,
      output mem_wb_ready,
      input  issue_valid, issue_addr,
      output reg_pending,
      output port_write_enable, port_write_addr, port_write_data
   );
endinterface

// File: rtl/w0rm_core_writeback_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port and keeps
// the pending-write scoreboard. Define W0RM_WB_ROUND_ROBIN_EN for round-robin, else mem wins.
module w0rm_core_writeback_arbiter #(
   parameter int DATA_WIDTH    = 8,
   parameter int NUM_REGISTERS = 4
) (
   input logic                        clk,
   input logic                        reset_n,
   w0rm_core_writeback_arbiter_if.slave wb
);
   localparam int ADDR_WIDTH = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1;
   localparam logic [NUM_REGISTERS-1:0] ONE_HOT_BASE = NUM_REGISTERS'(1);

   logic                     grant_alu;
   logic                     grant_mem;
   logic                     mem_wins;

   logic                     write_enable;
   logic [ADDR_WIDTH-1:0]    write_addr;
   logic [DATA_WIDTH-1:0]    write_data;

   logic [NUM_REGISTERS-1:0] pending;
   logic [NUM_REGISTERS-1:0] set_mask;
   logic [NUM_REGISTERS-1:0] clear_mask;

`ifdef W0RM_WB_ROUND_ROBIN_EN
   // Remembers who won last so the other side takes the next contested cycle.
   logic last_grant_mem;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_mem <= 1'b0;
      end else if (grant_alu || grant_mem) begin
         last_grant_mem <= grant_mem;
      end
   end

   assign mem_wins = !last_grant_mem;
`else
   assign mem_wins = 1'b1;
`endif

   always_comb begin
      grant_alu = 1'b0;
      grant_mem = 1'b0;
      if (!wb.flush) begin
         if (wb.mem_wb_valid && (!wb.alu_wb_valid || mem_wins)) begin
            grant_mem = 1'b1;
         end else if (wb.alu_wb_valid) begin
            grant_alu = 1'b1;
         end
      end
   end

   assign wb.alu_wb_ready = grant_alu;
   assign wb.mem_wb_ready = grant_mem;

   // Address and data hold their last values when no write is granted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         write_enable <= 1'b0;
         write_addr   <= '0;
         write_data   <= '0;
      end else begin
         write_enable <= grant_alu || grant_mem;
         if (grant_mem) begin
            write_addr <= wb.mem_wb_addr;
            write_data <= wb.mem_wb_data;
         end else if (grant_alu) begin
            write_addr <= wb.alu_wb_addr;
            write_data <= wb.alu_wb_data;
         end
      end
   end

   assign wb.port_write_enable = write_enable;
   assign wb.port_write_addr   = write_addr;
   assign wb.port_write_data   = write_data;

   always_comb begin
      set_mask   = '0;
      clear_mask = '0;
      if (wb.issue_valid) begin
         set_mask = ONE_HOT_BASE << wb.issue_addr;
      end
      if (write_enable) begin
         clear_mask = ONE_HOT_BASE << write_addr;
      end
   end

   // OR-ing the set after the clear lets a new issue win over a completing older write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending <= '0;
      end else if (wb.flush) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~clear_mask) | set_mask;
      end
   end

   assign wb.reg_pending = pending;

   single_grant_check : assert property (
      @(posedge clk) disable iff (!reset_n) !(wb.alu_wb_ready && wb.mem_wb_ready)
   );
endmodule

// File: tb/tb_w0rm_core_writeback_arbiter.sv
// Self-checking bench for the writeback arbiter: directed scenarios plus a randomized run
// compared against a behavioural model of the grant, write-port and scoreboard rules.
module tb_w0rm_core_writeback_arbiter;
   localparam int DW = 8;
   localparam int NR = 4;
   localparam int AW = 2;
`ifdef W0RM_WB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   w0rm_core_writeback_arbiter_if #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR)) bus ();

   w0rm_core_writeback_arbiter #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .wb      (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Stand-in register file fed by the write port.
   logic [DW-1:0] rf [NR];
   always @(posedge clk) begin
      if (bus.port_write_enable) rf[bus.port_write_addr] <= bus.port_write_data;
   end

   // Behavioural model state.
   bit            m_last_mem;
   bit            m_pend [NR];
   bit            m_pwe;
   logic [AW-1:0] m_pwa;
   logic [DW-1:0] m_pwd;

   function automatic void model_reset();
      m_last_mem = 1'b0;
      for (int r = 0; r < NR; r++) m_pend[r] = 1'b0;
      m_pwe = 1'b0;
      m_pwa = '0;
      m_pwd = '0;
   endfunction

   function automatic void model_step(input bit fl, input bit av, input logic [AW-1:0] aa,
                                      input logic [DW-1:0] ad, input bit mv,
                                      input logic [AW-1:0] ma, input logic [DW-1:0] md,
                                      input bit iv, input logic [AW-1:0] ia,
                                      output bit er_alu, output bit er_mem);
      bit mem_first;
      mem_first = RR ? !m_last_mem : 1'b1;
      er_alu = 1'b0;
      er_mem = 1'b0;
      if (!fl) begin
         if (av && mv) begin
            if (mem_first) er_mem = 1'b1;
            else           er_alu = 1'b1;
         end else if (av) er_alu = 1'b1;
         else if (mv)     er_mem = 1'b1;
      end
      for (int r = 0; r < NR; r++) begin
         if (fl)                       m_pend[r] = 1'b0;
         else if (iv && ia == r)       m_pend[r] = 1'b1;
         else if (m_pwe && m_pwa == r) m_pend[r] = 1'b0;
      end
      m_pwe = er_alu || er_mem;
      if (er_mem) begin
         m_pwa = ma; m_pwd = md; m_last_mem = 1'b1;
      end else if (er_alu) begin
         m_pwa = aa; m_pwd = ad; m_last_mem = 1'b0;
      end
   endfunction

   task automatic idle();
      bus.flush        = 1'b0;
      bus.alu_wb_valid = 1'b0;
      bus.alu_wb_addr  = '0;
      bus.alu_wb_data  = '0;
      bus.mem_wb_valid = 1'b0;
      bus.mem_wb_addr  = '0;
      bus.mem_wb_data  = '0;
      bus.issue_valid  = 1'b0;
      bus.issue_addr   = '0;
   endtask

   task automatic drive_alu(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.alu_wb_valid = v; bus.alu_wb_addr = a; bus.alu_wb_data = d;
   endtask

   task automatic drive_mem(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.mem_wb_valid = v; bus.mem_wb_addr = a; bus.mem_wb_data = d;
   endtask

   task automatic drive_issue(input bit v, input logic [AW-1:0] a);
      bus.issue_valid = v; bus.issue_addr = a;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      reset_n = 1'b0;
      #12;
      checks++;
      if (bus.port_write_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_pwe: got %0b expected 0", bus.port_write_enable); end
      checks++;
      if (bus.port_write_addr !== 2'd0) begin errors++; $display("[TB] FAIL reset_pwa: got %0h expected 0", bus.port_write_addr); end
      checks++;
      if (bus.port_write_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_pwd: got %0h expected 0", bus.port_write_data); end
      checks++;
      if (bus.reg_pending !== 4'b0000) begin errors++; $display("[TB] FAIL reset_pending: got %b expected 0000", bus.reg_pending); end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_alu_write();
      @(negedge clk);
      drive_alu(1'b1, 2'd2, 8'h5A);
      #1;
      checks++;
      if (bus.alu_wb_ready !== 1'b1) begin errors++; $display("[TB] FAIL alu_ready: got %0b expected 1", bus.alu_wb_ready); end
      checks++;
      if (bus.mem_wb_ready !== 1'b0) begin errors++; $display("[TB] FAIL mem_ready_idle: got %0b expected 0", bus.mem_wb_ready); end
      after_edge();
      checks++;
      if (bus.port_write_enable !== 1'b1) begin errors++; $display("[TB] FAIL alu_pwe: got %0b expected 1", bus.port_write_enable); end
      checks++;
      if (bus.port_write_addr !== 2'd2) begin errors++; $display("[TB] FAIL alu_pwa: got %0h expected 2", bus.port_write_addr); end
      checks++;
      if (bus.port_write_data !== 8'h5A) begin errors++; $display("[TB] FAIL alu_pwd: got %0h expected 5a", bus.port_write_data); end
      @(negedge clk);
      idle();
      after_edge();
      checks++;
      if (bus.port_write_enable !== 1'b0) begin errors++; $display("[TB] FAIL alu_pwe_drop: got %0b expected 0", bus.port_write_enable); end
      checks++;
      if (bus.port_write_addr !== 2'd2 || bus.port_write_data !== 8'h5A) begin
         errors++; $display("[TB] FAIL alu_hold: got %0h/%0h expected 2/5a", bus.port_write_addr, bus.port_write_data);
      end
      checks++;
      if (rf[2] !== 8'h5A) begin errors++; $display("[TB] FAIL rf_r2: got %0h expected 5a", rf[2]); end
   endtask

   task automatic test_contest();
      bit exp_mem;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) begin
            drive_alu(1'b1, 2'd1, 8'h11);
            drive_mem(1'b1, 2'd3, 8'h33);
         end
         exp_mem = RR ? (i % 2 == 0) : 1'b1;
         #1;
         checks++;
         if (bus.mem_wb_ready !== exp_mem || bus.alu_wb_ready !== !exp_mem) begin
            errors++;
            $display("[TB] FAIL contest_ready[%0d]: got alu=%0b mem=%0b expected alu=%0b mem=%0b",
                     i, bus.alu_wb_ready, bus.mem_wb_ready, !exp_mem, exp_mem);
         end
         after_edge();
         checks++;
         if (bus.port_write_addr !== (exp_mem ? 2'd3 : 2'd1) ||
             bus.port_write_data !== (exp_mem ? 8'h33 : 8'h11) || bus.port_write_enable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL contest_port[%0d]: got en=%0b addr=%0h data=%0h expected en=1 addr=%0h",
                     i, bus.port_write_enable, bus.port_write_addr, bus.port_write_data, exp_mem ? 3 : 1);
         end
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_scoreboard();
      @(negedge clk);
      drive_issue(1'b1, 2'd3);
      after_edge();
      checks++;
      if (bus.reg_pending !== 4'b1000) begin errors++; $display("[TB] FAIL sb_set: got %b expected 1000", bus.reg_pending); end
      @(negedge clk);
      drive_issue(1'b0, 2'd0);
      after_edge();
      checks++;
      if (bus.reg_pending !== 4'b1000) begin errors++; $display("[TB] FAIL sb_hold: got %b expected 1000", bus.reg_pending); end
      @(negedge clk);
      drive_mem(1'b1, 2'd3, 8'h77);
      #1;
      checks++;
      if (bus.mem_wb_ready !== 1'b1) begin errors++; $display("[TB] FAIL sb_mem_ready: got %0b expected 1", bus.mem_wb_ready); end
      after_edge();
      checks++;
      if (bus.reg_pending !== 4'b1000 || bus.port_write_enable !== 1'b1) begin
         errors++; $display("[TB] FAIL sb_accept: got pend=%b en=%0b expected 1000/1", bus.reg_pending, bus.port_write_enable);
      end
      @(negedge clk);
      drive_mem(1'b0, 2'd0, 8'h00);
      after_edge();
      checks++;
      if (bus.reg_pending !== 4'b0000) begin errors++; $display("[TB] FAIL sb_clear: got %b expected 0000", bus.reg_pending); end

      @(negedge clk);
      drive_issue(1'b1, 2'd3);
      @(negedge clk);
      drive_issue(1'b0, 2'd0);
      drive_mem(1'b1, 2'd3, 8'h78);
      @(negedge clk);
      drive_mem(1'b0, 2'd0, 8'h00);
      drive_issue(1'b1, 2'd3);
      after_edge();
      checks++;
      if (bus.reg_pending !== 4'b1000) begin errors++; $display("[TB] FAIL sb_set_wins: got %b expected 1000", bus.reg_pending); end
      @(negedge clk);
      drive_issue(1'b0, 2'd0);
      drive_mem(1'b1, 2'd3, 8'h79);
      @(negedge clk);
      drive_mem(1'b0, 2'd0, 8'h00);
      after_edge();
      checks++;
      if (bus.reg_pending !== 4'b0000) begin errors++; $display("[TB] FAIL sb_clear2: got %b expected 0000", bus.reg_pending); end
   endtask

   task automatic test_flush();
      @(negedge clk);
      idle();
      drive_issue(1'b1, 2'd1);
      @(negedge clk);
      drive_issue(1'b1, 2'd2);
      drive_alu(1'b1, 2'd0, 8'hA0);
      after_edge();
      checks++;
      if (bus.reg_pending !== 4'b0110) begin errors++; $display("[TB] FAIL flush_pre_pending: got %b expected 0110", bus.reg_pending); end
      @(negedge clk);
      bus.flush = 1'b1;
      drive_alu(1'b1, 2'd1, 8'h11);
      drive_mem(1'b1, 2'd3, 8'h33);
      drive_issue(1'b1, 2'd0);
      #1;
      checks++;
      if (bus.alu_wb_ready !== 1'b0 || bus.mem_wb_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL flush_ready: got alu=%0b mem=%0b expected 0/0", bus.alu_wb_ready, bus.mem_wb_ready);
      end
      checks++;
      if (bus.port_write_enable !== 1'b1 || bus.port_write_addr !== 2'd0 || bus.port_write_data !== 8'hA0) begin
         errors++; $display("[TB] FAIL flush_inflight: got en=%0b addr=%0h data=%0h expected 1/0/a0",
                            bus.port_write_enable, bus.port_write_addr, bus.port_write_data);
      end
      after_edge();
      checks++;
      if (bus.reg_pending !== 4'b0000) begin errors++; $display("[TB] FAIL flush_pending: got %b expected 0000", bus.reg_pending); end
      checks++;
      if (bus.port_write_enable !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_grant: got %0b expected 0", bus.port_write_enable); end
      checks++;
      if (rf[0] !== 8'hA0) begin errors++; $display("[TB] FAIL flush_rf_r0: got %0h expected a0", rf[0]); end
      @(negedge clk);
      idle();
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      drive_alu(1'b1, 2'd1, 8'h3C);
      drive_issue(1'b1, 2'd2);
      after_edge();
      checks++;
      if (bus.port_write_enable !== 1'b1 || bus.reg_pending !== 4'b0100) begin
         errors++; $display("[TB] FAIL areset_pre: got en=%0b pend=%b expected 1/0100", bus.port_write_enable, bus.reg_pending);
      end
      #1;
      idle();
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.port_write_enable !== 1'b0 || bus.port_write_addr !== 2'd0 ||
          bus.port_write_data !== 8'h00 || bus.reg_pending !== 4'b0000) begin
         errors++; $display("[TB] FAIL areset_outputs: got en=%0b addr=%0h data=%0h pend=%b expected all 0",
                            bus.port_write_enable, bus.port_write_addr, bus.port_write_data, bus.reg_pending);
      end
      @(negedge clk);
      reset_n = 1'b1;
      drive_alu(1'b1, 2'd1, 8'h44);
      drive_mem(1'b1, 2'd2, 8'h55);
      #1;
      checks++;
      if (bus.mem_wb_ready !== 1'b1 || bus.alu_wb_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL areset_first_contest: got alu=%0b mem=%0b expected 0/1", bus.alu_wb_ready, bus.mem_wb_ready);
      end
      after_edge();
      checks++;
      if (bus.port_write_addr !== 2'd2 || bus.port_write_data !== 8'h55) begin
         errors++; $display("[TB] FAIL areset_first_write: got %0h/%0h expected 2/55", bus.port_write_addr, bus.port_write_data);
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_random();
      bit            fl, av, mv, iv, er_alu, er_mem;
      logic [AW-1:0] aa, ma, ia;
      logic [DW-1:0] ad, md;
      logic [NR-1:0] exp_pend;
      @(negedge clk);
      idle();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      model_reset();
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         fl = ($urandom_range(0, 15) == 0);
         av = 1'($urandom_range(0, 1));
         mv = 1'($urandom_range(0, 1));
         iv = 1'($urandom_range(0, 1));
         aa = AW'($urandom); ma = AW'($urandom); ia = AW'($urandom);
         ad = DW'($urandom); md = DW'($urandom);
         bus.flush = fl;
         drive_alu(av, aa, ad);
         drive_mem(mv, ma, md);
         drive_issue(iv, ia);
         #1;
         model_step(fl, av, aa, ad, mv, ma, md, iv, ia, er_alu, er_mem);
         checks++;
         if (bus.alu_wb_ready !== er_alu || bus.mem_wb_ready !== er_mem) begin
            errors++; $display("[TB] FAIL rand_ready[%0d]: got alu=%0b mem=%0b expected alu=%0b mem=%0b",
                               cyc, bus.alu_wb_ready, bus.mem_wb_ready, er_alu, er_mem);
         end
         after_edge();
         for (int r = 0; r < NR; r++) exp_pend[r] = m_pend[r];
         checks++;
         if (bus.port_write_enable !== m_pwe || bus.port_write_addr !== m_pwa ||
             bus.port_write_data !== m_pwd) begin
            errors++; $display("[TB] FAIL rand_port[%0d]: got en=%0b addr=%0h data=%0h expected en=%0b addr=%0h data=%0h",
                               cyc, bus.port_write_enable, bus.port_write_addr, bus.port_write_data, m_pwe, m_pwa, m_pwd);
         end
         checks++;
         if (bus.reg_pending !== exp_pend) begin
            errors++; $display("[TB] FAIL rand_pending[%0d]: got %b expected %b", cyc, bus.reg_pending, exp_pend);
         end
      end
      @(negedge clk);
      idle();
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      idle();
      reset_n = 1'b0;
      test_reset();
      test_alu_write();
      test_contest();
      test_scoreboard();
      test_flush();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
